forward_hazard_unit: RTL

Parametrised successor to the per-operand forwarding logic. One block generates forwarding selects for NUM_SRC source operands in EX, with MEM taking priority over WB. It also generates load-use stalls and branch flushes. A single-entry scoreboard tracks one outstanding multi-cycle operation (mul/div) and stalls dependent or conflicting instructions in ID until the result is due.

---
 rtl/forward_hazard_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit
// EX-stage operand forwarding, load-use and branch hazard control, and a
// single-entry scoreboard for one outstanding multi-cycle (mul/div) op.
//
// Forwarding selects are purely combinational. Per slot, MEM has priority
// over WB, and register 0 never forwards.
//
// Stall/flush outputs are combinational, so the pipeline can act in the
// same cycle:
//   stall_f = stall_d = load-use || scoreboard hit
//   flush_d = taken branch in EX
//   flush_e = load-use || scoreboard hit || taken branch
//
// Scoreboard timing: an op issued with latency L (0 is treated as 1) keeps
// busy high for exactly L cycles after the issue edge. The entry retires on
// the edge that follows the cycle in which pend_cnt == 0. A new op may be
// accepted in that retiring cycle, so a back-to-back long op does not lose a
// cycle. An issue while the entry is still counting is dropped and sets err,
// which stays set until reset.
module forward_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0]         rd_ex,
    input  logic [REG_ADDR_W-1:0]         rd_mem,
    input  logic [REG_ADDR_W-1:0]         rd_wb,
    input  logic                          register_write_mem,
    input  logic                          register_write_wb,
    input  logic                          load_ex,
    input  logic                          long_issue_ex,
    input  logic [LAT_W-1:0]              long_latency_ex,
    input  logic                          long_id,
    input  logic                          pc_src_ex,
    output logic [2*NUM_SRC-1:0]          forward_e,
    output logic                          stall_f,
    output logic                          stall_d,
    output logic                          flush_d,
    output logic                          flush_e,
    output logic                          busy,
    output logic                          err
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [LAT_W-1:0]      CNT_ZERO = '0;
    localparam logic [LAT_W-1:0]      CNT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};

    // Scoreboard state
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [LAT_W-1:0]      pend_cnt;

    // Derived hazard terms
    logic                  load_use;
    logic                  sb_hit;
    logic                  pend_retiring;
    logic                  accept;
    logic                  conflict;
    logic [LAT_W-1:0]      init_cnt;

    // Per-slot forwarding select, MEM before WB, x0 never forwarded
    always_comb begin
        forward_e = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [REG_ADDR_W-1:0] rs;
            rs = rs_ex[i*REG_ADDR_W +: REG_ADDR_W];
            if (rs == REG_ZERO)
                forward_e[2*i +: 2] = FWD_RF;
            else if (register_write_mem && (rs == rd_mem))
                forward_e[2*i +: 2] = FWD_MEM;
            else if (register_write_wb && (rs == rd_wb))
                forward_e[2*i +: 2] = FWD_WB;
            else
                forward_e[2*i +: 2] = FWD_RF;
        end
    end

    // Load-use: an ID source reads the register a load in EX is about to write
    always_comb begin
        load_use = 1'b0;
        if (load_ex && (rd_ex != REG_ZERO)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == rd_ex)
                    load_use = 1'b1;
            end
        end
    end

    // Scoreboard hit: ID depends on the pending result, or wants the unit too
    always_comb begin
        sb_hit = 1'b0;
        if (pend_valid) begin
            if (long_id)
                sb_hit = 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((rs_id[i*REG_ADDR_W +: REG_ADDR_W] != REG_ZERO) &&
                    (rs_id[i*REG_ADDR_W +: REG_ADDR_W] == pend_rd))
                    sb_hit = 1'b1;
            end
        end
    end

    // Issue decode: accept into a free or retiring entry, flag a clash otherwise
    always_comb begin
        pend_retiring = pend_valid && (pend_cnt == CNT_ZERO);
        accept        = long_issue_ex && (rd_ex != REG_ZERO) &&
                        (!pend_valid || pend_retiring);
        conflict      = long_issue_ex && pend_valid && !pend_retiring;
        init_cnt      = (long_latency_ex == CNT_ZERO) ? CNT_ZERO
                                                      : (long_latency_ex - CNT_ONE);
    end

    // Scoreboard entry: allocate, count down, retire; sticky error on clash
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            pend_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            if (accept) begin
                pend_valid <= 1'b1;
                pend_rd    <= rd_ex;
                pend_cnt   <= init_cnt;
            end else if (pend_valid) begin
                if (pend_cnt != CNT_ZERO)
                    pend_cnt <= pend_cnt - CNT_ONE;
                else
                    pend_valid <= 1'b0;
            end
            if (conflict)
                err <= 1'b1;
        end
    end

    // Stall/flush combination; a taken branch never masks a stall
    always_comb begin
        stall_f = load_use || sb_hit;
        stall_d = load_use || sb_hit;
        flush_d = pc_src_ex;
        flush_e = load_use || sb_hit || pc_src_ex;
        busy    = pend_valid;
    end

endmodule
